immu_pt_loader: RTL

Page-table loader for the instruction MMU. On a start pulse it reads consecutive page-table words from memory over a request/acknowledge bus and replays each one as a special-register write into the IMMU page-table SR window (SR 0x100..0x10F). It is the writer side of the IMMU SR interface and replaces 16 back-to-back software SR writes on a context switch. Its SR outputs are muxed with the core's SR write port; `o_busy` stalls core SR writes.

---
 rtl/immu_pt_loader.sv | 108 ++++++++++
 1 files changed

// File: rtl/immu_pt_loader.sv
// IMMU page-table loader: fetches page-table words over a req/ack bus and replays them as SR writes.
// Optional IMMU_LOADER_HIGH_OFF_EN adds a trailing fetch written to the long-mode high-offset SR.
module immu_pt_loader #(
  parameter int unsigned N_ENTRIES = 16,
  parameter logic [15:0] SR_BASE   = 16'h100
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [23:0] i_base_addr,
  output logic        o_mem_req,
  output logic [23:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_data,
  output logic [15:0] o_sr_addr,
  output logic [15:0] o_sr_data,
  output logic        o_sr_we,
  output logic        o_busy,
  output logic        o_done
);

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 5;

`ifdef IMMU_LOADER_HIGH_OFF_EN
  localparam logic [IW-1:0] LAST_IDX = IW'(N_ENTRIES);
`else
  localparam logic [IW-1:0] LAST_IDX = IW'(N_ENTRIES - 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WR, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] data_q, data_d;

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // Next state; abort dominates ack and start, and an acked word is dropped on abort
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          addr_d  = i_base_addr;
          idx_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (i_mem_ack) begin
          data_d  = i_mem_data & 16'h0FFF;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          addr_d  = addr_q + AW'(1);
          state_d = S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode from registers only
  always_comb begin
    o_mem_req  = (state_q == S_REQ);
    o_mem_addr = addr_q;
    o_sr_we    = (state_q == S_WR);
    o_sr_addr  = SR_BASE + 16'(idx_q);
    o_busy     = (state_q != S_IDLE);
    o_done     = (state_q == S_DONE);
`ifdef IMMU_LOADER_HIGH_OFF_EN
    o_sr_data  = (idx_q == IW'(N_ENTRIES)) ? (data_q & 16'h00FF) : data_q;
`else
    o_sr_data  = data_q;
`endif
  end

endmodule
